ps2_rx: RTL



---
 rtl/ps2_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with clock glitch filter and valid/ready byte output.
// Define PS2_RX_TIMEOUT_EN to build the mid-frame watchdog; otherwise timeout_err is tied low.
module ps2_rx #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overrun
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [FW-1:0] flt_cnt;
    logic          filt;
    logic          filt_d;
    logic          fall;
    logic          bit_in;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;

    assign bit_in = dat_sync[1];

    // Synchronise both lines; the clock only moves after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            flt_cnt  <= '0;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            if (clk_sync[1] == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt    <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
            filt_d <= filt;
            fall   <= filt_d & ~filt;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Frame FSM, output register and (optionally) the inter-edge watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall && !bit_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg[bit_cnt] <= bit_in;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par   <= bit_in;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // A good byte arriving on the handshake cycle replaces the consumed one.
                    if (fall) begin
                        state <= IDLE;
                        if (!bit_in) begin
                            frame_err <= 1'b1;
                        end else if (!(^{shreg, par})) begin
                            parity_err <= 1'b1;
                        end else if (valid && !ready) begin
                            overrun <= 1'b1;
                        end else begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_RX_TIMEOUT_EN
            timeout_err <= 1'b0;
            if (state == IDLE || fall) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                state       <= IDLE;
                timeout_err <= 1'b1;
                tmo_cnt     <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
`endif
        end
    end

endmodule
